axi_rd_req_arbiter: RTL and testbench
=====================================

// Module: axi_rd_req_arbiter
// PURPOSE
//  Shares one AXI4 read master port (AR+R) between NREQ trace/DMA requesters.
//  Round-robin arbitration on AR; ARID carries the requester index, and R beats route back by RID.
//  Caps in-flight bursts at MAX_OUTS. Sits between requester agents and the AXI master trace entity.
// PARAMETERS
//  NREQ     4   number of requesters (2..8); IDW = $clog2(NREQ), minimum 1
//  ADDRW    32  address width
//  DATAW    32  data width
//  LENGTHW  4   ARLEN width
//  SIZEW    3   ARSIZE width
//  MAX_OUTS 8   maximum outstanding bursts (1..15); CNTW = $clog2(MAX_OUTS+1)
// PORTS
//  clk            in   1                clock
//  rst            in   1                synchronous, active-high reset
//  req_arvalid    in   NREQ             per-requester AR valid
//  req_arready    out  NREQ             per-requester AR ready (one-hot or zero)
//  req_araddr     in   NREQ*ADDRW       packed; requester i at [i*ADDRW +: ADDRW]
//  req_arlen      in   NREQ*LENGTHW     packed as above
//  req_arsize     in   NREQ*SIZEW       packed as above
//  req_arburst    in   NREQ*2           packed as above
//  req_rvalid     out  NREQ             per-requester R valid (one-hot or zero)
//  req_rready     in   NREQ             per-requester R ready
//  req_rdata/rresp/rlast out DATAW/2/1  R payload broadcast to all requesters
//  m_arvalid      out  1                master AR valid
//  m_arready      in   1                master AR ready
//  m_arid/araddr/arlen/arsize/arburst out IDW/ADDRW/LENGTHW/SIZEW/2   registered AR payload
//  m_rvalid       in   1                master R valid
//  m_rready       out  1                master R ready
//  m_rid/rdata/rresp/rlast in IDW/DATAW/2/1   master R payload
//  outstanding    out  CNTW             bursts issued, last beat not yet returned
//  id_err         out  1                sticky: R beat seen with m_rid >= NREQ
//  stat_grant_cnt out  NREQ*16          per-requester grant counters (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state=IDLE, rr_ptr=0, outstanding=0, id_err=0, m_arvalid=0.
//   All AR payload registers are 0. req_arready=0. Counters are 0.
//  FSM IDLE: if any req_arvalid and outstanding < MAX_OUTS:
//   - grant g = first valid requester at or after rr_ptr (wrapping at NREQ).
//   - assert req_arready[g] combinationally this cycle; latch its payload; set m_arid=g.
//   - set rr_ptr = (g+1)%NREQ; go to ISSUE.
//   Otherwise all req_arready stay 0.
//  FSM ISSUE: m_arvalid=1 with the payload held stable. On m_arready: outstanding+1, go to IDLE.
//  Latency: requester handshake in cycle N -> m_arvalid in N+1. At most one AR every 2 cycles.
//  Backpressure: m_arready low holds ISSUE indefinitely; no new grant is issued meanwhile.
//  R path is combinational and has no buffering:
//   - req_rvalid[m_rid] = m_rvalid; m_rready = req_rready[m_rid]; payload passes through.
//   - Handshake with rlast=1 -> outstanding-1.
//  Simultaneous AR accept and last-beat return in one cycle: outstanding unchanged.
//  Full: outstanding==MAX_OUTS blocks grants. A last-beat return that cycle does not unblock until the next cycle.
//  m_rid >= NREQ (only possible when NREQ is not a power of two): m_rready=1, beat dropped.
//   No req_rvalid; id_err set. A dropped beat with rlast=1 still decrements outstanding.
//  Outstanding never wraps: a decrement at 0 is ignored and sets id_err.
//  Reset mid-burst: all state is cleared immediately. In-flight R beats after reset are treated as normal beats.
//   The master must be reset together with this block.
// CONFIGURATION
//  AXI_RD_ARB_STATS_EN defined:
//   - stat_grant_cnt[i] increments on each req_arready[i] handshake.
//   - 16-bit, saturates at 16'hFFFF, cleared by rst.
//  Not defined: stat_grant_cnt is tied to 0 and no counter logic is built.
// TESTING
//  1. All 4 requesters hold arvalid, araddr=i*'h100, m_arready=1 -> grants 0,1,2,3,0 in order.
//     m_arid matches each grant; m_araddr=0,'h100,'h200,'h300.
//  2. MAX_OUTS=2, m_rvalid=0, 3 requests -> 2 ARs issue, outstanding=2, third arready stays 0.
//     One rlast return -> third AR issues on the following grant.
//  3. m_arready low 5 cycles in ISSUE -> m_arvalid/m_araddr stable, no req_arready pulses, outstanding unchanged.
//  4. R beats with m_rid=2, arlen=3 -> only req_rvalid[2] pulses, 4 beats.
//     req_rready[2]=0 stalls m_rready. Outstanding drops by 1 at rlast.
//  5. NREQ=3, inject m_rid=3, rlast=1 -> beat dropped, id_err=1 and sticky, no req_rvalid.
//  6. STATS_EN: 5 grants to requester 1 -> stat_grant_cnt[1]=5. Assert rst mid-ISSUE -> all outputs return to reset values next cycle.

Source files
------------

// File: rtl/axi_rd_req_arbiter.sv
// axi_rd_req_arbiter: shares one AXI4 read master (AR+R) between NREQ
// requesters. Round-robin AR arbitration tags each burst with the requester
// index on ARID; R beats are routed back combinationally by RID. The number
// of in-flight bursts is capped at MAX_OUTS.
// Optional feature macro: AXI_RD_ARB_STATS_EN builds per-requester 16-bit
// saturating grant counters on stat_grant_cnt; otherwise the port is 0.
// Handshake rule: a transfer happens on a rising clk edge where valid and
// ready are both high; valid never waits on ready, and the AR payload is
// held stable while m_arvalid is high and m_arready is low.
module axi_rd_req_arbiter #(
    parameter int NREQ     = 4,
    parameter int ADDRW    = 32,
    parameter int DATAW    = 32,
    parameter int LENGTHW  = 4,
    parameter int SIZEW    = 3,
    parameter int MAX_OUTS = 8,
    localparam int IDW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CNTW    = $clog2(MAX_OUTS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_arvalid,
    output logic [NREQ-1:0]         req_arready,
    input  logic [NREQ*ADDRW-1:0]   req_araddr,
    input  logic [NREQ*LENGTHW-1:0] req_arlen,
    input  logic [NREQ*SIZEW-1:0]   req_arsize,
    input  logic [NREQ*2-1:0]       req_arburst,
    output logic [NREQ-1:0]         req_rvalid,
    input  logic [NREQ-1:0]         req_rready,
    output logic [DATAW-1:0]        req_rdata,
    output logic [1:0]              req_rresp,
    output logic                    req_rlast,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [IDW-1:0]          m_arid,
    output logic [ADDRW-1:0]        m_araddr,
    output logic [LENGTHW-1:0]      m_arlen,
    output logic [SIZEW-1:0]        m_arsize,
    output logic [1:0]              m_arburst,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [IDW-1:0]          m_rid,
    input  logic [DATAW-1:0]        m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rlast,
    output logic [CNTW-1:0]         outstanding,
    output logic                    id_err,
    output logic [NREQ*16-1:0]      stat_grant_cnt
);

    typedef enum logic [0:0] {ST_IDLE, ST_ISSUE} state_t;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    grant_idx;
    logic              grant_found;
    logic              can_grant;
    logic              ar_fire;
    logic              last_fire;
    logic              rid_ok;
    logic [ADDRW-1:0]  sel_addr;
    logic [LENGTHW-1:0] sel_len;
    logic [SIZEW-1:0]  sel_size;
    logic [1:0]        sel_burst;

    // First valid requester at or after rr_ptr, wrapping at NREQ.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!grant_found && req_arvalid[(int'(rr_ptr) + k) % NREQ]) begin
                grant_found = 1'b1;
                grant_idx   = IDW'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Payload of the requester being granted this cycle.
    always_comb begin
        sel_addr  = '0;
        sel_len   = '0;
        sel_size  = '0;
        sel_burst = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == IDW'(i)) begin
                sel_addr  = req_araddr[i*ADDRW +: ADDRW];
                sel_len   = req_arlen[i*LENGTHW +: LENGTHW];
                sel_size  = req_arsize[i*SIZEW +: SIZEW];
                sel_burst = req_arburst[i*2 +: 2];
            end
        end
    end

    assign can_grant   = (state_q == ST_IDLE) && grant_found &&
                         (outstanding < CNTW'(MAX_OUTS));
    assign req_arready = can_grant ? (NREQ'(1) << grant_idx) : '0;
    assign m_arvalid   = (state_q == ST_ISSUE);
    assign ar_fire     = (state_q == ST_ISSUE) && m_arready;

    // R demux by RID; an out-of-range RID is sunk (ready high, no delivery).
    always_comb begin
        rid_ok     = 1'b0;
        req_rvalid = '0;
        m_rready   = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (m_rid == IDW'(i)) begin
                rid_ok        = 1'b1;
                req_rvalid[i] = m_rvalid;
                m_rready      = req_rready[i];
            end
        end
    end

    assign req_rdata = m_rdata;
    assign req_rresp = m_rresp;
    assign req_rlast = m_rlast;
    assign last_fire = m_rvalid && m_rready && m_rlast;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state: grant in IDLE, hold the AR in ISSUE until accepted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (can_grant) state_d = ST_ISSUE;
            ST_ISSUE: if (m_arready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Latch the granted payload and advance the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            m_arid    <= '0;
            m_araddr  <= '0;
            m_arlen   <= '0;
            m_arsize  <= '0;
            m_arburst <= '0;
        end else if (can_grant) begin
            rr_ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
            m_arid    <= grant_idx;
            m_araddr  <= sel_addr;
            m_arlen   <= sel_len;
            m_arsize  <= sel_size;
            m_arburst <= sel_burst;
        end
    end

    // In-flight burst count; simultaneous accept and last beat cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
        end else if (ar_fire && !last_fire) begin
            outstanding <= outstanding + 1'b1;
        end else if (last_fire && !ar_fire && outstanding != '0) begin
            outstanding <= outstanding - 1'b1;
        end
    end

    // Sticky error: unknown RID, or a last beat with nothing outstanding.
    always_ff @(posedge clk) begin
        if (rst) begin
            id_err <= 1'b0;
        end else if ((m_rvalid && !rid_ok) ||
                     (last_fire && !ar_fire && outstanding == '0)) begin
            id_err <= 1'b1;
        end
    end

`ifdef AXI_RD_ARB_STATS_EN
    logic [15:0] grant_cnt [NREQ];

    // Saturating per-requester grant counters.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NREQ; i++) begin
            if (rst) begin
                grant_cnt[i] <= '0;
            end else if (req_arready[i] && req_arvalid[i] &&
                         grant_cnt[i] != 16'hFFFF) begin
                grant_cnt[i] <= grant_cnt[i] + 16'd1;
            end
        end
    end

    // Pack counters onto the flat stats port.
    always_comb begin
        stat_grant_cnt = '0;
        for (int i = 0; i < NREQ; i++) begin
            stat_grant_cnt[i*16 +: 16] = grant_cnt[i];
        end
    end
`else
    assign stat_grant_cnt = '0;
`endif

endmodule

// File: tb/tb_axi_rd_req_arbiter.sv
// Directed testbench for axi_rd_req_arbiter. Instance u_a uses the default
// configuration (NREQ=4, MAX_OUTS=8); instance u_b uses NREQ=3, MAX_OUTS=2
// to reach the cap quickly and to produce an out-of-range RID.
// Inputs change just after the falling edge; outputs are sampled 1ns later.
module tb_axi_rd_req_arbiter;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- instance A: NREQ=4, MAX_OUTS=8 ----------------
    logic [3:0]   a_arvalid, a_arready, a_rvalid, a_rready;
    logic [127:0] a_araddr;
    logic [15:0]  a_arlen;
    logic [11:0]  a_arsize;
    logic [7:0]   a_arburst;
    logic [31:0]  a_rdata_o, a_m_araddr, a_m_rdata;
    logic [1:0]   a_rresp_o, a_m_arburst, a_m_arid, a_m_rid, a_m_rresp;
    logic         a_rlast_o, a_m_arvalid, a_m_arready, a_m_rvalid, a_m_rready, a_m_rlast;
    logic [3:0]   a_m_arlen, a_outstanding;
    logic [2:0]   a_m_arsize;
    logic         a_id_err;
    logic [63:0]  a_stat;

    axi_rd_req_arbiter u_a (
        .clk(clk), .rst(rst),
        .req_arvalid(a_arvalid), .req_arready(a_arready),
        .req_araddr(a_araddr), .req_arlen(a_arlen), .req_arsize(a_arsize),
        .req_arburst(a_arburst),
        .req_rvalid(a_rvalid), .req_rready(a_rready),
        .req_rdata(a_rdata_o), .req_rresp(a_rresp_o), .req_rlast(a_rlast_o),
        .m_arvalid(a_m_arvalid), .m_arready(a_m_arready), .m_arid(a_m_arid),
        .m_araddr(a_m_araddr), .m_arlen(a_m_arlen), .m_arsize(a_m_arsize),
        .m_arburst(a_m_arburst),
        .m_rvalid(a_m_rvalid), .m_rready(a_m_rready), .m_rid(a_m_rid),
        .m_rdata(a_m_rdata), .m_rresp(a_m_rresp), .m_rlast(a_m_rlast),
        .outstanding(a_outstanding), .id_err(a_id_err), .stat_grant_cnt(a_stat)
    );

    // ---------------- instance B: NREQ=3, MAX_OUTS=2 ----------------
    logic [2:0]  b_arvalid, b_arready, b_rvalid, b_rready;
    logic [95:0] b_araddr;
    logic [11:0] b_arlen;
    logic [8:0]  b_arsize;
    logic [5:0]  b_arburst;
    logic [31:0] b_rdata_o, b_m_araddr, b_m_rdata;
    logic [1:0]  b_rresp_o, b_m_arburst, b_m_arid, b_m_rid, b_m_rresp, b_outstanding;
    logic        b_rlast_o, b_m_arvalid, b_m_arready, b_m_rvalid, b_m_rready, b_m_rlast;
    logic [3:0]  b_m_arlen;
    logic [2:0]  b_m_arsize;
    logic        b_id_err;
    logic [47:0] b_stat;

    axi_rd_req_arbiter #(.NREQ(3), .MAX_OUTS(2)) u_b (
        .clk(clk), .rst(rst),
        .req_arvalid(b_arvalid), .req_arready(b_arready),
        .req_araddr(b_araddr), .req_arlen(b_arlen), .req_arsize(b_arsize),
        .req_arburst(b_arburst),
        .req_rvalid(b_rvalid), .req_rready(b_rready),
        .req_rdata(b_rdata_o), .req_rresp(b_rresp_o), .req_rlast(b_rlast_o),
        .m_arvalid(b_m_arvalid), .m_arready(b_m_arready), .m_arid(b_m_arid),
        .m_araddr(b_m_araddr), .m_arlen(b_m_arlen), .m_arsize(b_m_arsize),
        .m_arburst(b_m_arburst),
        .m_rvalid(b_m_rvalid), .m_rready(b_m_rready), .m_rid(b_m_rid),
        .m_rdata(b_m_rdata), .m_rresp(b_m_rresp), .m_rlast(b_m_rlast),
        .outstanding(b_outstanding), .id_err(b_id_err), .stat_grant_cnt(b_stat)
    );

`ifdef AXI_RD_ARB_STATS_EN
    localparam logic [15:0] EXP_STAT1 = 16'd5;
`else
    localparam logic [15:0] EXP_STAT1 = 16'd0;
`endif

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        a_arvalid = '0; a_rready = '0; a_m_arready = 1'b0;
        a_m_rvalid = 1'b0; a_m_rid = '0; a_m_rdata = '0; a_m_rresp = '0; a_m_rlast = 1'b0;
        b_arvalid = '0; b_rready = '0; b_m_arready = 1'b0;
        b_m_rvalid = 1'b0; b_m_rid = '0; b_m_rdata = '0; b_m_rresp = '0; b_m_rlast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a_araddr[i*32 +: 32] = 32'(i * 'h100);
            a_arlen[i*4 +: 4]    = 4'd3;
            a_arsize[i*3 +: 3]   = 3'd2;
            a_arburst[i*2 +: 2]  = 2'd1;
        end
        for (int i = 0; i < 3; i++) begin
            b_araddr[i*32 +: 32] = 32'(i * 'h10);
            b_arlen[i*4 +: 4]    = 4'd0;
            b_arsize[i*3 +: 3]   = 3'd2;
            b_arburst[i*2 +: 2]  = 2'd1;
        end

        repeat (2) tick();
        #1;
        check("rst_arvalid", a_m_arvalid, 0);
        check("rst_outstanding", a_outstanding, 0);
        check("rst_id_err", a_id_err, 0);
        check("rst_araddr", a_m_araddr, 0);
        check("rst_arready", a_arready, 0);
        check("rst_b_id_err", b_id_err, 0);
        rst = 1'b0;
        tick();

        // Round robin: all four requesters valid, grants 0,1,2,3,0.
        a_arvalid = 4'hF; a_m_arready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            #1 check("rr_arready", a_arready, 64'(1) << (n % 4));
            tick();
            #1;
            check("rr_m_arvalid", a_m_arvalid, 1);
            check("rr_m_arid", a_m_arid, n % 4);
            check("rr_m_araddr", a_m_araddr, (n % 4) * 'h100);
            check("rr_no_arready_in_issue", a_arready, 0);
            tick();
        end
        a_arvalid = 4'b0100; a_m_arready = 1'b0;
        #1;
        check("rr_outstanding", a_outstanding, 5);
        check("rr_m_arlen", a_m_arlen, 3);
        check("bp_grant2", a_arready, 4'b0100);
        tick();

        // Backpressure: ISSUE held 5 cycles with every requester valid.
        a_arvalid = 4'hF;
        repeat (5) begin
            #1;
            check("bp_m_arvalid", a_m_arvalid, 1);
            check("bp_m_araddr", a_m_araddr, 'h200);
            check("bp_arready", a_arready, 0);
            check("bp_outstanding", a_outstanding, 5);
            tick();
        end
        a_m_arready = 1'b1;
        tick();
        a_arvalid = '0;
        #1 check("bp_accept_outstanding", a_outstanding, 6);

        // R routing: rid=2, four beats, first beat stalled by requester.
        a_m_rvalid = 1'b1; a_m_rid = 2'd2; a_m_rdata = 32'hA0; a_m_rlast = 1'b0; a_rready = '0;
        #1;
        check("r_stall_rvalid", a_rvalid, 4'b0100);
        check("r_stall_m_rready", a_m_rready, 0);
        tick();
        a_rready = 4'b0100;
        for (int b = 0; b < 4; b++) begin
            a_m_rdata = 32'(32'hA0 + b); a_m_rlast = (b == 3);
            #1;
            check("r_rvalid", a_rvalid, 4'b0100);
            check("r_m_rready", a_m_rready, 1);
            check("r_rdata", a_rdata_o, 32'hA0 + b);
            check("r_rlast", a_rlast_o, b == 3);
            if (b == 3) check("r_before_last_outstanding", a_outstanding, 6);
            tick();
        end
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
        #1 check("r_after_last_outstanding", a_outstanding, 5);

        // Simultaneous AR accept and last-beat return.
        a_arvalid = 4'b0001;
        #1 check("sim_grant0", a_arready, 4'b0001);
        tick();
        a_arvalid = '0;
        a_m_rvalid = 1'b1; a_m_rid = 2'd1; a_m_rlast = 1'b1; a_rready = 4'b0010;
        #1 check("sim_m_rready", a_m_rready, 1);
        tick();
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
        #1;
        check("sim_outstanding", a_outstanding, 5);
        check("sim_m_arvalid", a_m_arvalid, 0);

        // Fill to MAX_OUTS=8 with grants 1,2,3, then verify the block.
        a_arvalid = 4'hF;
        repeat (6) tick();
        #1;
        check("full_outstanding", a_outstanding, 8);
        check("full_arready", a_arready, 0);
        tick();
        #1 check("full_m_arvalid", a_m_arvalid, 0);
        a_m_rvalid = 1'b1; a_m_rid = 2'd0; a_m_rlast = 1'b1; a_rready = 4'hF; a_m_arready = 1'b0;
        #1 check("full_return_cycle_arready", a_arready, 0);
        tick();
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
        #1;
        check("full_after_return_outstanding", a_outstanding, 7);
        check("full_unblocked_arready", a_arready, 4'b0001);
        tick();

        // Reset in the middle of ISSUE.
        a_arvalid = '0; rst = 1'b1;
        #1 check("mid_rst_pre_arvalid", a_m_arvalid, 1);
        tick();
        #1;
        check("mid_rst_m_arvalid", a_m_arvalid, 0);
        check("mid_rst_outstanding", a_outstanding, 0);
        check("mid_rst_m_arid", a_m_arid, 0);
        check("mid_rst_m_araddr", a_m_araddr, 0);
        check("mid_rst_m_arlen", a_m_arlen, 0);
        check("mid_rst_stat", a_stat, 0);
        rst = 1'b0;

        // Last beat with nothing outstanding: no wrap, id_err set.
        a_m_rvalid = 1'b1; a_m_rid = 2'd3; a_m_rlast = 1'b1; a_rready = 4'b1000; a_m_arready = 1'b1;
        #1 check("underflow_rvalid", a_rvalid, 4'b1000);
        tick();
        a_m_rvalid = 1'b0; a_m_rlast = 1'b0;
        #1;
        check("underflow_id_err", a_id_err, 1);
        check("underflow_outstanding", a_outstanding, 0);

        // Five grants to requester 1 for the statistics counters.
        a_arvalid = 4'b0010;
        repeat (10) tick();
        a_arvalid = '0;
        #1;
        check("stat_outstanding", a_outstanding, 5);
        check("stat_cnt1", a_stat[16 +: 16], EXP_STAT1);
        check("stat_cnt0", a_stat[0 +: 16], 0);

        // Instance B: MAX_OUTS=2 cap.
        tick();
        b_arvalid = 3'b111; b_m_arready = 1'b1;
        #1 check("cap_first_grant", b_arready, 3'b001);
        repeat (4) tick();
        #1;
        check("cap_outstanding", b_outstanding, 2);
        check("cap_arready_blocked", b_arready, 0);
        tick();
        #1 check("cap_m_arvalid", b_m_arvalid, 0);
        b_m_rvalid = 1'b1; b_m_rid = 2'd0; b_m_rlast = 1'b1; b_rready = 3'b111;
        #1 check("cap_return_cycle_arready", b_arready, 0);
        tick();
        b_m_rvalid = 1'b0; b_m_rlast = 1'b0;
        #1;
        check("cap_outstanding_after_return", b_outstanding, 1);
        check("cap_third_grant", b_arready, 3'b100);
        tick();
        b_arvalid = '0;
        #1;
        check("cap_third_m_arvalid", b_m_arvalid, 1);
        check("cap_third_m_arid", b_m_arid, 2);
        check("cap_third_m_araddr", b_m_araddr, 'h20);
        tick();

        // Instance B: RID 3 is out of range for NREQ=3.
        b_m_rvalid = 1'b1; b_m_rid = 2'd3; b_m_rlast = 1'b1; b_rready = 3'b111;
        #1;
        check("badid_rvalid", b_rvalid, 0);
        check("badid_m_rready", b_m_rready, 1);
        check("badid_id_err_pre", b_id_err, 0);
        tick();
        b_m_rvalid = 1'b0; b_m_rlast = 1'b0;
        #1;
        check("badid_id_err", b_id_err, 1);
        check("badid_outstanding", b_outstanding, 1);
        tick();
        #1 check("badid_id_err_sticky", b_id_err, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
